// File: rtl/mmio_periph_router_pkg.sv
// Shared peripheral definitions for the MMIO router and its address decoder:
// slave base addresses, register offsets, FSM state and slave-select encodings.
`timescale 1ns/1ps
package periph_pkg;

   // Peripheral windows, each 4 KiB wide
   localparam logic [31:0] SPI_BASE  = 32'h8000_0000;
   localparam logic [31:0] UART_BASE = 32'h8000_1000;

   // Page numbers compared against req_addr[31:12]
   localparam logic [19:0] SPI_PAGE  = SPI_BASE[31:12];
   localparam logic [19:0] UART_PAGE = UART_BASE[31:12];

   // SPI register byte offsets
   localparam logic [7:0] SPI_CTRL_OFS   = 8'h00;
   localparam logic [7:0] SPI_STATUS_OFS = 8'h04;
   localparam logic [7:0] SPI_TXDATA_OFS = 8'h08;
   localparam logic [7:0] SPI_RXDATA_OFS = 8'h0C;
   localparam logic [7:0] SPI_CLKDIV_OFS = 8'h10;
   localparam logic [7:0] SPI_CS_OFS     = 8'h14;

   // UART register byte offsets
   localparam logic [7:0] UART_TXDATA_OFS = 8'h00;
   localparam logic [7:0] UART_RXDATA_OFS = 8'h04;
   localparam logic [7:0] UART_STATUS_OFS = 8'h08;
   localparam logic [7:0] UART_CTRL_OFS   = 8'h0C;
   localparam logic [7:0] UART_BAUD_OFS   = 8'h10;
   localparam logic [7:0] UART_IRQEN_OFS  = 8'h14;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } router_state_t;

   typedef enum logic [1:0] {
      SEL_SPI,
      SEL_UART,
      SEL_MISS
   } periph_sel_t;

   // Slaves only decode the low byte of the address within their window
   function automatic logic [7:0] page_offset(input logic [31:0] addr);
      return addr[7:0];
   endfunction

endpackage

// File: rtl/mmio_periph_router_if.sv
// Request/response handshake between the router (master) and one MMIO slave.
// The slave's interrupt line travels back on the same bundle.
`timescale 1ns/1ps
interface mmio_if #(
   parameter int ADDR_W = 13
);
   logic              mmio_valid;
   logic              mmio_ready;
   logic              mmio_we;
   logic [ADDR_W-1:0] mmio_addr;
   logic [31:0]       mmio_wdata;
   logic [3:0]        mmio_wstrb;
   logic [31:0]       mmio_rdata;
   logic              irq_o;

   modport master (
      output mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
      input  mmio_ready, mmio_rdata, irq_o
   );

   modport slave (
      input  mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
      output mmio_ready, mmio_rdata, irq_o
   );
endinterface

// File: rtl/mmio_periph_router_addr_decode.sv
// Combinational page decode of a 32-bit byte address into a peripheral select.
// Kept separate so other address-window logic can share the same decode.
`timescale 1ns/1ps
module mmio_addr_decode
   import periph_pkg::*;
(
   input  logic [31:0] req_addr,
   output periph_sel_t sel
);

   // Offset bits within the page play no part in selecting a slave
   logic unused_offset;
   assign unused_offset = ^req_addr[11:0];

   // Match the 4 KiB page number against each peripheral window
   always_comb begin
      sel = SEL_MISS;
      if (req_addr[31:12] == SPI_PAGE) begin
         sel = SEL_SPI;
      end else if (req_addr[31:12] == UART_PAGE) begin
         sel = SEL_UART;
      end
   end

endmodule

// File: rtl/mmio_periph_router.sv
// Single-outstanding MMIO router from the core load/store unit to the SPI and
// UART slaves. One request is latched, the decoded slave is driven until it
// answers, and a one-cycle response pulse is returned. Page misses answer
// immediately with an error. Slave interrupts are merged into irq_o.
// Optional feature macro MMIO_ROUTER_TIMEOUT_EN: abort a slave access that has
// not completed within TIMEOUT_CYCLES busy cycles and answer with an error.
`timescale 1ns/1ps
module mmio_periph_router
   import periph_pkg::*;
#(
   parameter int ADDR_W = 13
`ifdef MMIO_ROUTER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,

   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,

   mmio_if.master      spi_m,
   mmio_if.master      uart_m,

   output logic        irq_o
);

`ifdef MMIO_ROUTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

   router_state_t     state_q, state_d;
   periph_sel_t       sel_q, sel_d;
   periph_sel_t       dec_sel;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              spi_valid_q, spi_valid_d;
   logic              uart_valid_q, uart_valid_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic              irq_q, irq_d;
`ifdef MMIO_ROUTER_TIMEOUT_EN
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
`endif

   logic              slave_ready;
   logic [31:0]       slave_rdata;

   mmio_addr_decode u_decode (
      .req_addr (req_addr),
      .sel      (dec_sel)
   );

   // A ready only counts on the port we are actually driving; the idle port's
   // ready is masked by its valid being low
   assign slave_ready = (spi_valid_q && spi_m.mmio_ready) ||
                        (uart_valid_q && uart_m.mmio_ready);
   assign slave_rdata = (sel_q == SEL_UART) ? uart_m.mmio_rdata : spi_m.mmio_rdata;

   // Next-state logic for the transaction FSM and all registered outputs
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      spi_valid_d  = spi_valid_q;
      uart_valid_d = uart_valid_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      irq_d        = spi_m.irq_o | uart_m.irq_o;
`ifdef MMIO_ROUTER_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
`endif

      unique case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_ready_q && req_valid) begin
               req_ready_d = 1'b0;
               sel_d       = dec_sel;
               we_d        = req_we;
               addr_d      = ADDR_W'(page_offset(req_addr));
               wdata_d     = req_wdata;
               wstrb_d     = req_wstrb;
               if (dec_sel == SEL_MISS) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else begin
                  state_d      = BUSY;
                  spi_valid_d  = (dec_sel == SEL_SPI);
                  uart_valid_d = (dec_sel == SEL_UART);
`ifdef MMIO_ROUTER_TIMEOUT_EN
                  tmo_cnt_d    = '0;
`endif
               end
            end
         end

         BUSY: begin
            if (slave_ready) begin
               spi_valid_d  = 1'b0;
               uart_valid_d = 1'b0;
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? 32'h0 : slave_rdata;
            end
`ifdef MMIO_ROUTER_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               spi_valid_d  = 1'b0;
               uart_valid_d = 1'b0;
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = 32'h0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end

         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d      = IDLE;
            spi_valid_d  = 1'b0;
            uart_valid_d = 1'b0;
            req_ready_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight access silently
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= SEL_MISS;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'h0;
         spi_valid_q  <= 1'b0;
         uart_valid_q <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
         irq_q        <= 1'b0;
`ifdef MMIO_ROUTER_TIMEOUT_EN
         tmo_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         spi_valid_q  <= spi_valid_d;
         uart_valid_q <= uart_valid_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         irq_q        <= irq_d;
`ifdef MMIO_ROUTER_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign irq_o      = irq_q;

   assign spi_m.mmio_valid  = spi_valid_q;
   assign spi_m.mmio_we     = we_q;
   assign spi_m.mmio_addr   = addr_q;
   assign spi_m.mmio_wdata  = wdata_q;
   assign spi_m.mmio_wstrb  = wstrb_q;

   assign uart_m.mmio_valid = uart_valid_q;
   assign uart_m.mmio_we    = we_q;
   assign uart_m.mmio_addr  = addr_q;
   assign uart_m.mmio_wdata = wdata_q;
   assign uart_m.mmio_wstrb = wstrb_q;

endmodule

// File: tb/tb_mmio_periph_router.sv
// Directed self-checking bench for mmio_periph_router: reset values, UART read,
// decode miss, stalled SPI write, IRQ merge, reset mid-access and (when
// MMIO_ROUTER_TIMEOUT_EN is defined) the busy timeout.
`timescale 1ns/1ps
module tb_mmio_periph_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        irq_o;

   int check_cnt = 0;
   int fail_cnt  = 0;
   int spi_valid_cycles  = 0;
   int uart_valid_cycles = 0;
   int resp_pulses       = 0;

   mmio_if #(.ADDR_W(13)) spi_if ();
   mmio_if #(.ADDR_W(13)) uart_if ();

   mmio_periph_router #(
      .ADDR_W (13)
`ifdef MMIO_ROUTER_TIMEOUT_EN
      , .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .spi_m      (spi_if),
      .uart_m     (uart_if),
      .irq_o      (irq_o)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Count cycles in which each slave valid and the response pulse are high
   always @(negedge clk) begin
      if (spi_if.mmio_valid === 1'b1) spi_valid_cycles++;
      if (uart_if.mmio_valid === 1'b1) uart_valid_cycles++;
      if (resp_valid === 1'b1) resp_pulses++;
   end

   // Abort a run that stops making progress
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_cnt++;
      if (actual !== expected) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request and return in cycle 1 (the cycle after the accept edge)
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      int waited;
      waited = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("req_ready_before_accept", 32'(req_ready), 32'h1);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_wstrb = 4'h0;
   endtask

   initial begin
      int spi_snap;
      int uart_snap;
      int resp_snap;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_wstrb  = 4'h0;
      spi_if.mmio_ready  = 1'b0;
      spi_if.mmio_rdata  = 32'h0;
      spi_if.irq_o       = 1'b0;
      uart_if.mmio_ready = 1'b0;
      uart_if.mmio_rdata = 32'h0;
      uart_if.irq_o      = 1'b0;

      // ---------------- reset values ----------------
      tick();
      tick();
      checkOutput("rst_req_ready",  32'(req_ready), 32'h0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_resp_err",   32'(resp_err), 32'h0);
      checkOutput("rst_irq",        32'(irq_o), 32'h0);
      checkOutput("rst_spi_valid",  32'(spi_if.mmio_valid), 32'h0);
      checkOutput("rst_uart_valid", 32'(uart_if.mmio_valid), 32'h0);
      checkOutput("rst_mmio_addr",  32'(spi_if.mmio_addr), 32'h0);
      checkOutput("rst_mmio_we",    32'(spi_if.mmio_we), 32'h0);
      checkOutput("rst_mmio_wdata", spi_if.mmio_wdata, 32'h0);
      checkOutput("rst_mmio_wstrb", 32'(spi_if.mmio_wstrb), 32'h0);
      rst = 1'b0;
      tick();
      checkOutput("idle_req_ready", 32'(req_ready), 32'h1);

      // Stray slave ready while idle must not produce a response
      resp_snap = resp_pulses;
      spi_if.mmio_ready = 1'b1;
      spi_if.mmio_rdata = 32'hFFFF_FFFF;
      tick();
      spi_if.mmio_ready = 1'b0;
      tick();
      checkOutput("stray_ready_no_resp", 32'(resp_pulses - resp_snap), 32'h0);
      checkOutput("stray_ready_still_idle", 32'(req_ready), 32'h1);

      // ---------------- UART read, ready in cycle 1 ----------------
      spi_snap  = spi_valid_cycles;
      uart_snap = uart_valid_cycles;
      applyStimulus(1'b0, 32'h8000_1004, 32'h0, 4'h0);
      checkOutput("uart_rd_valid_c1", 32'(uart_if.mmio_valid), 32'h1);
      checkOutput("uart_rd_addr",     32'(uart_if.mmio_addr), 32'h004);
      checkOutput("uart_rd_we",       32'(uart_if.mmio_we), 32'h0);
      uart_if.mmio_ready = 1'b1;
      uart_if.mmio_rdata = 32'h0000_0003;
      tick();
      uart_if.mmio_ready = 1'b0;
      uart_if.mmio_rdata = 32'hDEAD_BEEF;
      checkOutput("uart_rd_resp_valid_c2", 32'(resp_valid), 32'h1);
      checkOutput("uart_rd_rdata",         resp_rdata, 32'h0000_0003);
      checkOutput("uart_rd_err",           32'(resp_err), 32'h0);
      checkOutput("uart_rd_valid_dropped", 32'(uart_if.mmio_valid), 32'h0);
      tick();
      checkOutput("uart_rd_resp_one_cycle", 32'(resp_valid), 32'h0);
      checkOutput("uart_rd_rdata_held",     resp_rdata, 32'h0000_0003);
      checkOutput("uart_rd_ready_c3",       32'(req_ready), 32'h1);
      checkOutput("uart_rd_spi_never_valid", 32'(spi_valid_cycles - spi_snap), 32'h0);
      checkOutput("uart_rd_uart_valid_cycles", 32'(uart_valid_cycles - uart_snap), 32'h1);

      // ---------------- decode miss ----------------
      spi_snap  = spi_valid_cycles;
      uart_snap = uart_valid_cycles;
      applyStimulus(1'b0, 32'h4000_0000, 32'h0, 4'h0);
      checkOutput("miss_resp_valid_c1", 32'(resp_valid), 32'h1);
      checkOutput("miss_err",           32'(resp_err), 32'h1);
      checkOutput("miss_rdata",         resp_rdata, 32'h0);
      tick();
      checkOutput("miss_resp_one_cycle", 32'(resp_valid), 32'h0);
      checkOutput("miss_err_held",       32'(resp_err), 32'h1);
      checkOutput("miss_ready_c2",       32'(req_ready), 32'h1);
      checkOutput("miss_no_spi_valid",   32'(spi_valid_cycles - spi_snap), 32'h0);
      checkOutput("miss_no_uart_valid",  32'(uart_valid_cycles - uart_snap), 32'h0);

      // ---------------- SPI write with 5-cycle stall ----------------
      spi_snap  = spi_valid_cycles;
      uart_snap = uart_valid_cycles;
      applyStimulus(1'b1, 32'h8000_000C, 32'h0000_00A5, 4'h1);
      for (int i = 1; i <= 5; i++) begin
         checkOutput($sformatf("spi_wr_stall_valid_c%0d", i), 32'(spi_if.mmio_valid), 32'h1);
         tick();
      end
      checkOutput("spi_wr_valid_c6", 32'(spi_if.mmio_valid), 32'h1);
      checkOutput("spi_wr_addr",     32'(spi_if.mmio_addr), 32'h00C);
      checkOutput("spi_wr_we",       32'(spi_if.mmio_we), 32'h1);
      checkOutput("spi_wr_wdata",    spi_if.mmio_wdata, 32'h0000_00A5);
      checkOutput("spi_wr_wstrb",    32'(spi_if.mmio_wstrb), 32'h1);
      checkOutput("spi_wr_no_early_resp", 32'(resp_valid), 32'h0);
      spi_if.mmio_ready = 1'b1;
      spi_if.mmio_rdata = 32'h1234_5678;
      tick();
      spi_if.mmio_ready = 1'b0;
      checkOutput("spi_wr_resp_valid", 32'(resp_valid), 32'h1);
      checkOutput("spi_wr_rdata",      resp_rdata, 32'h0);
      checkOutput("spi_wr_err",        32'(resp_err), 32'h0);
      checkOutput("spi_wr_valid_dropped", 32'(spi_if.mmio_valid), 32'h0);
      checkOutput("spi_wr_valid_cycles",  32'(spi_valid_cycles - spi_snap), 32'h6);
      checkOutput("spi_wr_uart_never_valid", 32'(uart_valid_cycles - uart_snap), 32'h0);
      tick();

      // ---------------- IRQ pulse while busy on UART ----------------
      applyStimulus(1'b0, 32'h8000_1008, 32'h0, 4'h0);
      checkOutput("irq_idle_low", 32'(irq_o), 32'h0);
      spi_if.irq_o = 1'b1;
      tick();
      spi_if.irq_o = 1'b0;
      checkOutput("irq_high_next_cycle", 32'(irq_o), 32'h1);
      checkOutput("irq_uart_still_valid", 32'(uart_if.mmio_valid), 32'h1);
      tick();
      checkOutput("irq_one_cycle", 32'(irq_o), 32'h0);
      uart_if.mmio_ready = 1'b1;
      uart_if.mmio_rdata = 32'h0000_0055;
      tick();
      uart_if.mmio_ready = 1'b0;
      checkOutput("irq_uart_resp_valid", 32'(resp_valid), 32'h1);
      checkOutput("irq_uart_rdata",      resp_rdata, 32'h0000_0055);
      checkOutput("irq_uart_err",        32'(resp_err), 32'h0);
      tick();

      // ---------------- reset during SPI stall ----------------
      resp_snap = resp_pulses;
      applyStimulus(1'b1, 32'h8000_0010, 32'hCAFE_0001, 4'hF);
      checkOutput("rstbusy_spi_valid", 32'(spi_if.mmio_valid), 32'h1);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("rstbusy_spi_valid_dropped", 32'(spi_if.mmio_valid), 32'h0);
      checkOutput("rstbusy_req_ready",  32'(req_ready), 32'h0);
      checkOutput("rstbusy_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rstbusy_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rstbusy_resp_err",   32'(resp_err), 32'h0);
      checkOutput("rstbusy_mmio_addr",  32'(spi_if.mmio_addr), 32'h0);
      checkOutput("rstbusy_mmio_wdata", spi_if.mmio_wdata, 32'h0);
      checkOutput("rstbusy_mmio_wstrb", 32'(spi_if.mmio_wstrb), 32'h0);
      checkOutput("rstbusy_mmio_we",    32'(spi_if.mmio_we), 32'h0);
      rst = 1'b0;
      tick();
      checkOutput("rstbusy_no_resp", 32'(resp_pulses - resp_snap), 32'h0);
      applyStimulus(1'b0, 32'h8000_1000, 32'h0, 4'h0);
      uart_if.mmio_ready = 1'b1;
      uart_if.mmio_rdata = 32'h0000_0077;
      tick();
      uart_if.mmio_ready = 1'b0;
      checkOutput("post_rst_resp_valid", 32'(resp_valid), 32'h1);
      checkOutput("post_rst_rdata",      resp_rdata, 32'h0000_0077);
      checkOutput("post_rst_err",        32'(resp_err), 32'h0);
      checkOutput("post_rst_single_resp", 32'(resp_pulses - resp_snap), 32'h0);
      tick();
      checkOutput("post_rst_resp_count", 32'(resp_pulses - resp_snap), 32'h1);

`ifdef MMIO_ROUTER_TIMEOUT_EN
      // ---------------- timeout: UART never ready ----------------
      begin
         int busy_cycles;
         busy_cycles = 0;
         applyStimulus(1'b0, 32'h8000_1014, 32'h0, 4'h0);
         while (uart_if.mmio_valid === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            tick();
         end
         checkOutput("tmo_busy_cycles", 32'(busy_cycles), 32'd16);
         checkOutput("tmo_resp_valid",  32'(resp_valid), 32'h1);
         checkOutput("tmo_err",         32'(resp_err), 32'h1);
         checkOutput("tmo_rdata",       resp_rdata, 32'h0);
         tick();
         applyStimulus(1'b0, 32'h8000_1004, 32'h0, 4'h0);
         uart_if.mmio_ready = 1'b1;
         uart_if.mmio_rdata = 32'h0000_0009;
         tick();
         uart_if.mmio_ready = 1'b0;
         checkOutput("tmo_next_resp_valid", 32'(resp_valid), 32'h1);
         checkOutput("tmo_next_rdata",      resp_rdata, 32'h0000_0009);
         checkOutput("tmo_next_err",        32'(resp_err), 32'h0);
         tick();
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
      $finish;
   end

endmodule
